// File: rtl/mc_controller_if.sv
// Bus between the multicycle datapath and its controller: instruction fields
// and the ALU zero flag in, write enables, mux selects and the debug state out.
interface mc_controller_if;
    // No valid/ready handshake: the fields are sampled every cycle, and every
    // output is valid in the same cycle as the state it belongs to.
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcen;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic       immext;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        output op, funct, zero,
        input  memwrite, irwrite, regwrite, pcen, iord, regdst, memtoreg,
               alusrca, immext, pcsrc, alusrcb, alucontrol, state
    );

    modport slave (
        input  op, funct, zero,
        output memwrite, irwrite, regwrite, pcen, iord, regdst, memtoreg,
               alusrca, immext, pcsrc, alusrcb, alucontrol, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM: Moore outputs per state, with pcen
// additionally depending combinationally on the ALU zero flag in BEQ/BNE.
module mc_controller (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTEXE   = 4'd6,  S_ALUWB  = 4'd7,
        S_BEQ     = 4'd8,  S_BNE     = 4'd9,  S_ADDIEXE = 4'd10, S_ANDIEXE = 4'd11,
        S_ORIEXE  = 4'd12, S_IWB     = 4'd13, S_JUMP    = 4'd14, S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q, state_n;
    logic       memwrite, irwrite, regwrite, pcwrite, iord, regdst, memtoreg;
    logic       alusrca, immext, branch_eq, branch_ne;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = S_FETCH;
        case (state_q)
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_RTEXE;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_BNE:       state_n = S_BNE;
                    OP_ADDI:      state_n = S_ADDIEXE;
                    OP_ANDI:      state_n = S_ANDIEXE;
                    OP_ORI:       state_n = S_ORIEXE;
                    OP_J:         state_n = S_JUMP;
                    default:      state_n = S_FETCH;
                endcase
            end
            S_MEMADR:  state_n = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_n = S_MEMWB;
            S_RTEXE:   state_n = S_ALUWB;
            S_ADDIEXE, S_ANDIEXE, S_ORIEXE: state_n = S_IWB;
            default:   state_n = S_FETCH;
        endcase
    end

    always_comb begin
        memwrite = 1'b0; irwrite  = 1'b0; regwrite = 1'b0; pcwrite    = 1'b0;
        iord     = 1'b0; regdst   = 1'b0; memtoreg = 1'b0; alusrca    = 1'b0;
        immext   = 1'b0; pcsrc    = 2'b00; alusrcb = 2'b00; alucontrol = 3'b000;
        branch_eq = 1'b0; branch_ne = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01; alucontrol = 3'b010; irwrite = 1'b1; pcwrite = 1'b1;
            end
            // Speculatively form the branch target while the opcode is decoded.
            S_DECODE: begin
                alusrcb = 2'b11; alucontrol = 3'b010;
            end
            S_MEMADR, S_ADDIEXE: begin
                alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord = 1'b1; memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1; regwrite = 1'b1;
            end
            S_RTEXE: begin
                alusrca = 1'b1;
                case (bus.funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            S_ALUWB: begin
                regdst = 1'b1; regwrite = 1'b1;
            end
            S_ANDIEXE, S_ORIEXE: begin
                alusrca = 1'b1; alusrcb = 2'b10; immext = 1'b1;
                alucontrol = (state_q == S_ORIEXE) ? 3'b001 : 3'b000;
            end
            S_IWB: regwrite = 1'b1;
            S_BEQ, S_BNE: begin
                alusrca = 1'b1; alucontrol = 3'b110; pcsrc = 2'b01;
                branch_eq = (state_q == S_BEQ);
                branch_ne = (state_q == S_BNE);
            end
            S_JUMP: begin
                pcsrc = 2'b10; pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Reset is synchronous, so the register may still hold a mid-instruction
        // state; hold every enable low and present FETCH selects until it clears.
        if (!reset) begin
            memwrite = 1'b0; irwrite = 1'b0; regwrite = 1'b0; pcwrite = 1'b0;
            branch_eq = 1'b0; branch_ne = 1'b0;
            iord = 1'b0; regdst = 1'b0; memtoreg = 1'b0; alusrca = 1'b0; immext = 1'b0;
            pcsrc = 2'b00; alusrcb = 2'b01; alucontrol = 3'b010;
        end
    end

    assign bus.pcen       = pcwrite | (branch_eq & bus.zero) | (branch_ne & ~bus.zero);
    assign bus.memwrite   = memwrite;
    assign bus.irwrite    = irwrite;
    assign bus.regwrite   = regwrite;
    assign bus.iord       = iord;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.alusrca    = alusrca;
    assign bus.immext     = immext;
    assign bus.pcsrc      = pcsrc;
    assign bus.alusrcb    = alusrcb;
    assign bus.alucontrol = alucontrol;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each instruction pushes its expected
// per-cycle control words to a queue, which are popped and compared per cycle.
module tb_mc_controller;
    localparam int W = 20;

    typedef struct packed {
        logic [3:0] state;
        logic       memwrite, irwrite, regwrite, pcen;
        logic       iord, regdst, memtoreg, alusrca, immext;
        logic [1:0] pcsrc, alusrcb;
        logic [2:0] alucontrol;
    } ctrl_t;

    logic clk;
    logic reset;
    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int total_cnt = 0;
    int pass_cnt  = 0;

    // Expected control word for a state, straight from the per-state table.
    function automatic logic [W-1:0] model(input logic [3:0] st, input logic [5:0] f,
                                           input logic z, input logic rst);
        ctrl_t c;
        c = '0;
        c.state = st;
        case (st)
            4'd0:  begin c.alusrcb = 2'b01; c.alucontrol = 3'b010; c.irwrite = 1'b1; c.pcen = 1'b1; end
            4'd1:  begin c.alusrcb = 2'b11; c.alucontrol = 3'b010; end
            4'd2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
            4'd3:  c.iord = 1'b1;
            4'd4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            4'd5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            4'd6:  begin
                c.alusrca = 1'b1;
                if (f == 6'b100000)      c.alucontrol = 3'b010;
                else if (f == 6'b100010) c.alucontrol = 3'b110;
                else if (f == 6'b100100) c.alucontrol = 3'b000;
                else if (f == 6'b100101) c.alucontrol = 3'b001;
                else if (f == 6'b101010) c.alucontrol = 3'b111;
                else                     c.alucontrol = 3'b010;
            end
            4'd7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            4'd8:  begin c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
            4'd9:  begin c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = ~z; end
            4'd10: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
            4'd11: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.immext = 1'b1; c.alucontrol = 3'b000; end
            4'd12: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.immext = 1'b1; c.alucontrol = 3'b001; end
            4'd13: c.regwrite = 1'b1;
            4'd14: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
            default: ;
        endcase
        if (!rst) begin
            c.memwrite = 1'b0; c.irwrite = 1'b0; c.regwrite = 1'b0; c.pcen = 1'b0;
            c.iord = 1'b0; c.regdst = 1'b0; c.memtoreg = 1'b0; c.alusrca = 1'b0; c.immext = 1'b0;
            c.pcsrc = 2'b00; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
        end
        return c;
    endfunction

    function automatic logic [W-1:0] observed();
        ctrl_t c;
        c.state = bus.state;       c.memwrite = bus.memwrite; c.irwrite = bus.irwrite;
        c.regwrite = bus.regwrite; c.pcen = bus.pcen;         c.iord = bus.iord;
        c.regdst = bus.regdst;     c.memtoreg = bus.memtoreg; c.alusrca = bus.alusrca;
        c.immext = bus.immext;     c.pcsrc = bus.pcsrc;       c.alusrcb = bus.alusrcb;
        c.alucontrol = bus.alucontrol;
        return c;
    endfunction

    task automatic check(input string tag, input int idx);
        logic [W-1:0] exp_v, obs_v;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("FAIL %s[%0d]: scoreboard empty, observed %h required an entry", tag, idx, observed());
            return;
        end
        exp_v = exp_q.pop_front();
        obs_v = observed();
        total_cnt++;
        assert (obs_v === exp_v) pass_cnt++;
        else $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs_v, exp_v);
    endtask

    // seq holds up to five state codes, first state in the top nibble.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] funct,
                             input logic z, input logic [19:0] seq, input int len);
        logic [3:0] st;
        bus.op = op;
        bus.funct = funct;
        bus.zero = z;
        for (int i = 0; i < len; i++) begin
            st = seq[19-4*i -: 4];
            exp_q.push_back(model(st, funct, z, 1'b1));
        end
        for (int i = 0; i < len; i++) begin
            check(tag, i);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.op = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(model(4'd0, 6'b000000, 1'b0, 1'b0));
            check("reset_hold", i);
        end
        reset = 1'b1;
        #1;

        run_instr("lw",        6'b100011, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 5);
        run_instr("sw",        6'b101011, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 4);
        run_instr("r_slt",     6'b000000, 6'b101010, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
        run_instr("r_sub",     6'b000000, 6'b100010, 1'b1, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
        run_instr("r_and",     6'b000000, 6'b100100, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
        run_instr("r_or",      6'b000000, 6'b100101, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
        run_instr("r_badfn",   6'b000000, 6'b111111, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}, 3);
        run_instr("beq_not",   6'b000100, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}, 3);
        run_instr("bne_taken", 6'b000101, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 3);
        run_instr("bne_not",   6'b000101, 6'b000000, 1'b1, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 3);
        run_instr("addi",      6'b001000, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd10, 4'd13, 4'd0}, 4);
        run_instr("andi",      6'b001100, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd11, 4'd13, 4'd0}, 4);
        run_instr("ori",       6'b001101, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd12, 4'd13, 4'd0}, 4);
        run_instr("j",         6'b000010, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd14, 4'd0, 4'd0}, 3);
        run_instr("undef_op",  6'b111111, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 2);

        // lw interrupted by reset while in MEMRD.
        run_instr("lw_pre",    6'b100011, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd2, 4'd0, 4'd0}, 3);
        exp_q.push_back(model(4'd3, 6'b000000, 1'b0, 1'b1));
        check("lw_memrd", 0);
        reset = 1'b0;
        #1;
        exp_q.push_back(model(4'd3, 6'b000000, 1'b0, 1'b0));
        check("mid_reset_hold", 0);
        @(posedge clk);
        #1;
        exp_q.push_back(model(4'd0, 6'b000000, 1'b0, 1'b0));
        check("mid_reset_fetch", 0);
        reset = 1'b1;
        #1;
        run_instr("j_after",   6'b000010, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd14, 4'd0, 4'd0}, 4);

        total_cnt++;
        assert (exp_q.size() == 0) pass_cnt++;
        else $error("FAIL scoreboard_drain: observed %0d entries left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
